// File: rtl/expand_s_ctrl_pkg.sv
// Shared constants for the ExpandS sequencer: FSM encoding, SHA core control codes and
// ML-DSA-44 size defaults.
package expand_s_ctrl_pkg;

  // ML-DSA-44 defaults
  localparam int unsigned LDefault         = 4;
  localparam int unsigned KDefault         = 4;
  localparam int unsigned NumCoef          = 256;
  localparam int unsigned SeedWordsDefault = 8;
  localparam int unsigned RateWordsDefault = 17;

  // SHA core mode select
  localparam logic ShaModeShake128 = 1'b0;
  localparam logic ShaModeShake256 = 1'b1;

  // Valid bytes in the final absorb word
  localparam logic [1:0] ByteNumFull = 2'b00;
  localparam logic [1:0] ByteNum2B   = 2'b01;

  // Sequencer state encoding
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StAbsorb  = 3'd1;
  localparam logic [2:0] StSqueeze = 3'd2;
  localparam logic [2:0] StNext    = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

endpackage

// File: rtl/expand_s_ctrl.sv
// ExpandS sequencer: for each of L+K secret polynomials absorbs rho' || nonce into the shared
// SHAKE256 core, then squeezes until the rejection sampler has accepted N coefficients.
module expand_s_ctrl
  import expand_s_ctrl_pkg::*;
#(
  parameter int unsigned L          = LDefault,
  parameter int unsigned K          = KDefault,
  parameter int unsigned SeedWords  = SeedWordsDefault,
  parameter int unsigned RateWords  = RateWordsDefault,
  parameter int unsigned N          = NumCoef
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] poly_idx,
  output logic       poly_done,
  output logic [2:0] seed_rd_addr,
  output logic       absorb_nonce,
  output logic       sha_in_ready,
  output logic       sha_is_last,
  output logic [1:0] sha_byte_num,
  output logic       sha_mode,
  output logic       sha_squeeze,
  output logic       sha_sha_hold,
  input  logic       sha_out_ready,
  input  logic       samp_stall,
  input  logic       coef_acc_valid,
  input  logic [4:0] coef_acc_cnt
);

  localparam int unsigned NumPoly = L + K;

  logic [2:0] state_q, state_d;
  // Absorb word index while absorbing, squeeze word index within the rate block while squeezing
  logic [4:0] wcnt_q, wcnt_d;
  logic [8:0] coef_cnt_q, coef_cnt_d;
  logic [3:0] poly_idx_q, poly_idx_d;

  logic       consume;
  logic       reach_n;
  logic [9:0] coef_sum;

  assign consume  = (state_q == StSqueeze) && sha_out_ready && !samp_stall;
  assign coef_sum = {1'b0, coef_cnt_q} + {5'b0, coef_acc_cnt};
  // Polynomial completes on the report that brings the total to N; surplus is the sampler's job
  assign reach_n  = (state_q == StSqueeze) && coef_acc_valid && (coef_sum >= 10'(N));

  // Next-state and counter update
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    coef_cnt_d = coef_cnt_q;
    poly_idx_d = poly_idx_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StAbsorb;
          wcnt_d     = 5'd0;
          coef_cnt_d = 9'd0;
          poly_idx_d = 4'd0;
        end
      end
      StAbsorb: begin
        if (wcnt_q == 5'(SeedWords)) begin
          state_d = StSqueeze;
          wcnt_d  = 5'd0;
        end else begin
          wcnt_d = wcnt_q + 5'd1;
        end
      end
      StSqueeze: begin
        // The core re-permutes on its own at a block boundary; only the index wraps here
        if (consume) begin
          wcnt_d = (wcnt_q == 5'(RateWords - 1)) ? 5'd0 : wcnt_q + 5'd1;
        end
        if (coef_acc_valid) begin
          coef_cnt_d = (coef_sum >= 10'(N)) ? 9'(N) : coef_sum[8:0];
        end
        if (reach_n) begin
          state_d = StNext;
        end
      end
      StNext: begin
        wcnt_d     = 5'd0;
        coef_cnt_d = 9'd0;
        if (poly_idx_q == 4'(NumPoly - 1)) begin
          state_d = StDone;
        end else begin
          poly_idx_d = poly_idx_q + 4'd1;
          state_d    = StAbsorb;
        end
      end
      StDone: begin
        state_d    = StIdle;
        poly_idx_d = 4'd0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      wcnt_q     <= 5'd0;
      coef_cnt_q <= 9'd0;
      poly_idx_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      coef_cnt_q <= coef_cnt_d;
      poly_idx_q <= poly_idx_d;
    end
  end

  // Output decode from state, plus the sampler-driven squeeze handshakes
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    poly_done    = 1'b0;
    seed_rd_addr = 3'd0;
    absorb_nonce = 1'b0;
    sha_in_ready = 1'b0;
    sha_is_last  = 1'b0;
    sha_byte_num = ByteNumFull;
    sha_mode     = ShaModeShake128;
    sha_squeeze  = 1'b0;
    sha_sha_hold = 1'b0;
    case (state_q)
      StAbsorb: begin
        busy         = 1'b1;
        sha_mode     = ShaModeShake256;
        sha_in_ready = 1'b1;
        if (wcnt_q == 5'(SeedWords)) begin
          // Final word carries the 16-bit nonce
          absorb_nonce = 1'b1;
          sha_is_last  = 1'b1;
          sha_byte_num = ByteNum2B;
        end else begin
          seed_rd_addr = wcnt_q[2:0];
        end
      end
      StSqueeze: begin
        busy         = 1'b1;
        sha_mode     = ShaModeShake256;
        sha_squeeze  = 1'b1;
        sha_sha_hold = samp_stall;
        poly_done    = reach_n;
      end
      StNext: begin
        busy     = 1'b1;
        sha_mode = ShaModeShake256;
      end
      StDone: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign poly_idx = poly_idx_q;

endmodule

// File: tb/tb_expand_s_ctrl.sv
// Self-checking bench for expand_s_ctrl: a procedural protocol model (loops over polynomials,
// absorb words and squeeze words) drives the sampler side and predicts every output per cycle.
module tb_expand_s_ctrl;

  localparam int NPoly  = 8;
  localparam int NCoeff = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done, poly_done, absorb_nonce, sha_in_ready, sha_is_last;
  logic       sha_mode, sha_squeeze, sha_sha_hold;
  logic [3:0] poly_idx;
  logic [2:0] seed_rd_addr;
  logic [1:0] sha_byte_num;
  logic       sha_out_ready, samp_stall, coef_acc_valid;
  logic [4:0] coef_acc_cnt;

  expand_s_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .poly_idx      (poly_idx),
    .poly_done     (poly_done),
    .seed_rd_addr  (seed_rd_addr),
    .absorb_nonce  (absorb_nonce),
    .sha_in_ready  (sha_in_ready),
    .sha_is_last   (sha_is_last),
    .sha_byte_num  (sha_byte_num),
    .sha_mode      (sha_mode),
    .sha_squeeze   (sha_squeeze),
    .sha_sha_hold  (sha_sha_hold),
    .sha_out_ready (sha_out_ready),
    .samp_stall    (samp_stall),
    .coef_acc_valid(coef_acc_valid),
    .coef_acc_cnt  (coef_acc_cnt)
  );

  always #5 clk = ~clk;

  // Expected outputs for the current cycle
  logic       e_busy, e_done, e_pdone, e_nonce, e_inrdy, e_last, e_mode, e_sq, e_hold;
  logic [3:0] e_pidx;
  logic [2:0] e_addr;
  logic [1:0] e_bnum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_seen, done_at, pd_seen, sq_len, last_sq_len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs();
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("poly_idx", 32'(poly_idx), 32'(e_pidx));
    chk("poly_done", 32'(poly_done), 32'(e_pdone));
    chk("seed_rd_addr", 32'(seed_rd_addr), 32'(e_addr));
    chk("absorb_nonce", 32'(absorb_nonce), 32'(e_nonce));
    chk("sha_in_ready", 32'(sha_in_ready), 32'(e_inrdy));
    chk("sha_is_last", 32'(sha_is_last), 32'(e_last));
    chk("sha_byte_num", 32'(sha_byte_num), 32'(e_bnum));
    chk("sha_mode", 32'(sha_mode), 32'(e_mode));
    chk("sha_squeeze", 32'(sha_squeeze), 32'(e_sq));
    chk("sha_sha_hold", 32'(sha_sha_hold), 32'(e_hold));
  endtask

  task automatic set_idle_exp();
    e_busy = 0; e_done = 0; e_pdone = 0; e_nonce = 0; e_inrdy = 0; e_last = 0;
    e_mode = 0; e_sq = 0; e_hold = 0; e_pidx = 4'd0; e_addr = 3'd0; e_bnum = 2'b00;
  endtask

  task automatic set_busy_exp(input int p);
    set_idle_exp();
    e_busy = 1; e_mode = 1; e_pidx = 4'(p);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic random_sampler();
    sha_out_ready  = 1'($urandom);
    samp_stall     = 1'($urandom);
    coef_acc_valid = 1'($urandom);
    coef_acc_cnt   = 5'($urandom_range(0, 16));
  endtask

  // Compare and monitor, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      check_outputs();
      if (done) begin
        done_seen++;
        done_at = cyc;
      end
      if (sha_squeeze) sq_len++;
      if (poly_done) begin
        pd_seen++;
        last_sq_len = sq_len;
        sq_len = 0;
      end
    end
  end

  // One full ExpandS run. pat selects sampler behaviour; abort_poly >= 0 pulls reset mid-squeeze.
  task automatic run_op(input int pat, input int abort_poly);
    int sum, w, sc, start_snap;
    logic rdy, stl, vld;
    logic [4:0] cnt;
    set_idle_exp();
    sha_out_ready = 0; samp_stall = 0; coef_acc_valid = 0; coef_acc_cnt = 0;
    start = 1;
    start_snap = cyc;
    done_seen = 0; pd_seen = 0; sq_len = 0; last_sq_len = -1;
    step();
    for (int p = 0; p < NPoly; p++) begin
      for (int a = 0; a <= 8; a++) begin
        set_busy_exp(p);
        e_inrdy = 1;
        if (a < 8) begin
          e_addr = 3'(a);
        end else begin
          e_nonce = 1; e_last = 1; e_bnum = 2'b01;
        end
        start = ($urandom % 6) == 0;
        random_sampler();
        step();
      end
      sum = 0; w = 0; sc = 0;
      while (1) begin
        case (pat)
          1: begin rdy = 1; stl = 0; cnt = 5'd16; end
          2: begin rdy = 1; stl = 0; cnt = 5'd3; end
          3: begin rdy = 1; stl = 0; cnt = (w == 16) ? 5'd16 : 5'd15; end
          4: begin rdy = 1; stl = (sc >= 4 && sc < 9); cnt = 5'd16; end
          default: begin
            rdy = ($urandom % 4) != 0;
            stl = ($urandom % 4) == 0;
            cnt = 5'($urandom_range(0, 16));
          end
        endcase
        vld = rdy && !stl;
        sha_out_ready = rdy; samp_stall = stl; coef_acc_valid = vld; coef_acc_cnt = cnt;
        start = ($urandom % 9) == 0;
        if (p == abort_poly && sc == 6) begin
          samp_stall = 1;
          start = 0;
          reset = 0;
          set_idle_exp();
          #1;
          check_outputs();
          step();
          step();
          reset = 1;
          step();
          return;
        end
        set_busy_exp(p);
        e_sq = 1;
        e_hold = stl;
        e_pdone = vld && (sum + int'(cnt) >= NCoeff);
        step();
        sc++;
        if (vld) begin
          sum += int'(cnt);
          w++;
        end
        if (e_pdone) break;
        if (sc > 4000) begin
          chk("squeeze_bound", 32'(sc), 32'd4000);
          break;
        end
      end
      set_busy_exp(p);
      start = ($urandom % 3) == 0;
      random_sampler();
      step();
    end
    set_idle_exp();
    e_done = 1;
    e_pidx = 4'(NPoly - 1);
    start = 1;
    random_sampler();
    step();
    start = 0;
    set_idle_exp();
    step();
    step();
    chk("done_pulses", 32'(done_seen), 32'd1);
    chk("poly_done_pulses", 32'(pd_seen), 32'd8);
    case (pat)
      1: begin
        chk("last_poly_squeeze_cycles", 32'(last_sq_len), 32'd16);
        chk("done_latency", 32'(done_at - (start_snap + 1)), 32'd209);
      end
      2: chk("last_poly_squeeze_cycles", 32'(last_sq_len), 32'd86);
      3: chk("last_poly_squeeze_cycles", 32'(last_sq_len), 32'd17);
      4: chk("last_poly_squeeze_cycles", 32'(last_sq_len), 32'd21);
      default: ;
    endcase
  endtask

  initial begin
    reset = 0;
    start = 0;
    sha_out_ready = 0; samp_stall = 0; coef_acc_valid = 0; coef_acc_cnt = 0;
    set_idle_exp();
    step();
    step();
    reset = 1;
    step();
    run_op(1, -1);
    run_op(1, 3);
    run_op(1, -1);
    run_op(2, -1);
    run_op(3, -1);
    run_op(4, -1);
    for (int i = 0; i < 3; i++) run_op(0, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
